// File: rtl/mult_operand_sequencer.sv
// Operand sequencer wrapped around the 4x4 combinational array multiplier.
// It loads m then q over a shared nibble bus, waits for the product to settle, and keeps a running sum.
module mult_operand_sequencer #(
    parameter int SETTLE_CYCLES = 1,   // legal range 1..15
    parameter int ACC_W         = 12   // must be >= 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [3:0]       mult_m,
    output logic [3:0]       mult_q,
    input  logic [7:0]       mult_p,
    output logic [7:0]       prod,
    output logic             prod_valid,
    input  logic             prod_ready,
    input  logic             acc_clear,
    output logic [ACC_W-1:0] acc,
    output logic             acc_ovf,
    output logic             busy
);

    // Handshakes: a transfer happens on any rising edge where valid and ready are both high.
    // din_ready depends only on state. prod_valid is held high until that transfer occurs.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_Q = 2'd1,
        SETTLE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t         state;
    logic [3:0]     settle_cnt;
    logic           din_fire;
    logic           capture;
    logic [ACC_W:0] acc_sum;

    assign din_ready = (state == IDLE) || (state == LOAD_Q);
    assign busy      = (state != IDLE);
    assign din_fire  = din_valid && din_ready;
    assign capture   = (state == SETTLE) && (settle_cnt == 4'd1);
    // The extra top bit is the carry-out that sets the sticky overflow flag.
    assign acc_sum   = {1'b0, acc} + (ACC_W+1)'(mult_p);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            settle_cnt <= 4'd0;
            mult_m     <= 4'd0;
            mult_q     <= 4'd0;
            prod       <= 8'd0;
            prod_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (din_fire) begin
                        mult_m <= din;
                        state  <= LOAD_Q;
                    end
                end
                LOAD_Q: begin
                    if (din_fire) begin
                        mult_q     <= din;
                        settle_cnt <= 4'(SETTLE_CYCLES);
                        state      <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (capture) begin
                        prod       <= mult_p;
                        prod_valid <= 1'b1;
                        state      <= HOLD;
                    end
                    settle_cnt <= settle_cnt - 4'd1;
                end
                HOLD: begin
                    if (prod_ready) begin
                        prod_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A clear that lands on a capture edge wipes the old sum and keeps only the new product.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            acc_ovf <= 1'b0;
        end else if (acc_clear) begin
            acc     <= capture ? ACC_W'(mult_p) : '0;
            acc_ovf <= 1'b0;
        end else if (capture) begin
            acc     <= acc_sum[ACC_W-1:0];
            acc_ovf <= acc_ovf | acc_sum[ACC_W];
        end
    end

endmodule

// File: tb/tb_mult_operand_sequencer.sv
// Directed bench for mult_operand_sequencer with three instances, at settle times of 1, 4 and 3 cycles.
// Each instance's mult_p comes from a behavioural multiply of that instance's own operand outputs.
module tb_mult_operand_sequencer;

    localparam int ACC_W = 12;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [3:0]       din = 4'd0;
    logic             din_valid = 1'b0;
    logic             prod_ready = 1'b1;
    logic             acc_clear = 1'b0;

    logic [2:0]       din_ready;
    logic [3:0]       mult_m [3];
    logic [3:0]       mult_q [3];
    logic [7:0]       mult_p [3];
    logic [7:0]       prod [3];
    logic [2:0]       prod_valid;
    logic [ACC_W-1:0] acc [3];
    logic [2:0]       acc_ovf;
    logic [2:0]       busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        assign mult_p[g] = 8'(mult_m[g] * mult_q[g]);
        mult_operand_sequencer #(
            .SETTLE_CYCLES(g == 0 ? 1 : (g == 1 ? 4 : 3)),
            .ACC_W(ACC_W)
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .din(din),
            .din_valid(din_valid),
            .din_ready(din_ready[g]),
            .mult_m(mult_m[g]),
            .mult_q(mult_q[g]),
            .mult_p(mult_p[g]),
            .prod(prod[g]),
            .prod_valid(prod_valid[g]),
            .prod_ready(prod_ready),
            .acc_clear(acc_clear),
            .acc(acc[g]),
            .acc_ovf(acc_ovf[g]),
            .busy(busy[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] v);
        din       = v;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
    endtask

    task automatic chk_zero(input int i, input string tag);
        chk({tag, "_m"}, mult_m[i], 0);
        chk({tag, "_q"}, mult_q[i], 0);
        chk({tag, "_prod"}, prod[i], 0);
        chk({tag, "_acc"}, acc[i], 0);
        chk({tag, "_pv"}, prod_valid[i], 0);
        chk({tag, "_ovf"}, acc_ovf[i], 0);
        chk({tag, "_busy"}, busy[i], 0);
        chk({tag, "_rdy"}, din_ready[i], 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state of all three instances, checked while rst is held.
        #1;
        for (int i = 0; i < 3; i++) chk_zero(i, "reset");
        step();
        rst = 1'b0;

        // Test 1: 3*5 with a settle time of 1.
        prod_ready = 1'b1;
        send(4'd3);
        chk("t1_m", mult_m[0], 3);
        chk("t1_busy", busy[0], 1);
        chk("t1_rdy_loadq", din_ready[0], 1);
        send(4'd5);
        chk("t1_q", mult_q[0], 5);
        chk("t1_rdy_settle", din_ready[0], 0);
        chk("t1_pv_early", prod_valid[0], 0);
        step();
        chk("t1_prod", prod[0], 15);
        chk("t1_pv", prod_valid[0], 1);
        chk("t1_acc", acc[0], 15);
        step();
        chk("t1_pv_drop", prod_valid[0], 0);
        chk("t1_idle", busy[0], 0);
        chk("t1_prod_keep", prod[0], 15);

        // Test 2: 15*15 under backpressure while din_valid stays high with din=7.
        prod_ready = 1'b0;
        send(4'd15);
        send(4'd15);
        step();
        din       = 4'd7;
        din_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            chk("t2_prod", prod[0], 225);
            chk("t2_pv", prod_valid[0], 1);
            chk("t2_rdy", din_ready[0], 0);
            chk("t2_m", mult_m[0], 15);
            step();
        end
        chk("t2_acc", acc[0], 240);
        prod_ready = 1'b1;
        step();
        chk("t2_pv_drop", prod_valid[0], 0);
        chk("t2_idle", busy[0], 0);
        chk("t2_m_hold", mult_m[0], 15);
        step();
        din_valid = 1'b0;
        chk("t2_m_new", mult_m[0], 7);
        chk("t2_loadq", busy[0], 1);

        // Test 3: nineteen 15*15 transactions wrap the 12-bit accumulator.
        do_reset();
        for (int n = 0; n < 19; n++) begin
            if (n == 18) begin
                chk("t3_acc_pre", acc[0], 4050);
                chk("t3_ovf_pre", acc_ovf[0], 0);
            end
            send(4'd15);
            send(4'd15);
            step();
            step();
        end
        chk("t3_acc_wrap", acc[0], 179);
        chk("t3_ovf", acc_ovf[0], 1);
        acc_clear = 1'b1;
        step();
        acc_clear = 1'b0;
        chk("t3_acc_clr", acc[0], 0);
        chk("t3_ovf_clr", acc_ovf[0], 0);

        // Test 4: a clear that coincides with a capture edge.
        send(4'd10);
        send(4'd10);
        step();
        step();
        chk("t4_acc_100", acc[0], 100);
        send(4'd2);
        send(4'd3);
        acc_clear = 1'b1;
        step();
        acc_clear = 1'b0;
        chk("t4_acc", acc[0], 6);
        chk("t4_ovf", acc_ovf[0], 0);
        chk("t4_prod", prod[0], 6);
        step();

        // Test 5: settle time of 4, then a reset asserted in the middle of SETTLE.
        do_reset();
        send(4'd3);
        send(4'd3);
        step();
        step();
        step();
        chk("t5_pv_early", prod_valid[1], 0);
        step();
        chk("t5_pv", prod_valid[1], 1);
        chk("t5_acc", acc[1], 9);
        step();
        send(4'd7);
        send(4'd9);
        step();
        rst = 1'b1;
        #1;
        chk_zero(1, "t5_rst");
        step();
        rst = 1'b0;
        send(4'd0);
        send(4'd9);
        step();
        step();
        step();
        chk("t5b_pv_early", prod_valid[1], 0);
        step();
        chk("t5b_pv", prod_valid[1], 1);
        chk("t5b_prod", prod[1], 0);
        chk("t5b_q", mult_q[1], 9);
        step();
        chk("t5b_pv_drop", prod_valid[1], 0);

        // Test 6: settle time of 3, with operands 12 and 10.
        do_reset();
        send(4'd12);
        send(4'd10);
        step();
        chk("t6_pv_e1", prod_valid[2], 0);
        step();
        chk("t6_pv_e2", prod_valid[2], 0);
        step();
        chk("t6_pv_e3", prod_valid[2], 1);
        chk("t6_prod", prod[2], 120);
        chk("t6_acc", acc[2], 120);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
